// File: rtl/timer_run_ctrl_if.sv
// Signal bundle between timer_run_ctrl and its neighbours: user pulses, the
// clock_divider tick and the timer_minsec digits/controls.
interface timer_run_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       mode;
  logic       tick_in;
  logic [3:0] sec_low_digit;
  logic [2:0] sec_high_digit;
  logic [3:0] min_low_digit;
  logic       pause;
  logic       up_down;
  logic       tick_out;
  logic       timer_clear;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output start_stop, clear, mode, tick_in, sec_low_digit, sec_high_digit, min_low_digit,
    input  pause, up_down, tick_out, timer_clear, alarm, state
  );

  modport slave (
    input  start_stop, clear, mode, tick_in, sec_low_digit, sec_high_digit, min_low_digit,
    output pause, up_down, tick_out, timer_clear, alarm, state
  );
endinterface

// File: rtl/timer_run_ctrl.sv
// Run/stop sequencer for the min:sec timer: gates the count enable and stops at the
// terminal value instead of wrapping. Define ALARM_BLINK_EN for a blinking alarm.
module timer_run_ctrl #(
  parameter int UP_LIMIT_MIN  = 9,
  parameter int UP_LIMIT_SEC  = 59,
  parameter int ALARM_TIMEOUT = 0,
  parameter int BLINK_DIV     = 4
) (
  input  logic             clk,
  input  logic             reset,
  timer_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int              TO_W        = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(ALARM_TIMEOUT - 1);
  localparam logic [3:0]      TERM_MIN    = 4'(UP_LIMIT_MIN);
  localparam logic [2:0]      TERM_SEC_HI = 3'(UP_LIMIT_SEC / 10);
  localparam logic [3:0]      TERM_SEC_LO = 4'(UP_LIMIT_SEC % 10);

`ifdef ALARM_BLINK_EN
  localparam int              BL_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
  logic [BL_W-1:0] blink_cnt_r;
`endif

  state_t          state_r;
  logic            pause_r;
  logic            up_down_r;
  logic            timer_clear_r;
  logic            alarm_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            at_term_s;
  logic            timeout_s;

  function automatic logic term_hit(input logic up, input logic [3:0] mn,
                                    input logic [2:0] sh, input logic [3:0] sl);
    if (up) begin
      return (mn == TERM_MIN) && (sh == TERM_SEC_HI) && (sl == TERM_SEC_LO);
    end else begin
      return (mn == 4'd0) && (sh == 3'd0) && (sl == 4'd0);
    end
  endfunction

  // Terminal value for the current direction and the DONE dwell limit.
  always_comb begin
    at_term_s = term_hit(up_down_r, bus.min_low_digit, bus.sec_high_digit, bus.sec_low_digit);
    timeout_s = 1'b0;
    if (ALARM_TIMEOUT != 0) begin
      timeout_s = (to_cnt_r == TO_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Sequencer: one event per cycle, clear > start_stop > mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      pause_r       <= 1'b1;
      up_down_r     <= 1'b1;
      timer_clear_r <= 1'b0;
      alarm_r       <= 1'b0;
      to_cnt_r      <= '0;
`ifdef ALARM_BLINK_EN
      blink_cnt_r   <= '0;
`endif
    end else begin
      timer_clear_r <= 1'b0;
      // Dwell counters sit at zero outside DONE so every DONE entry starts fresh.
      if (state_r != ST_DONE) begin
        to_cnt_r    <= '0;
`ifdef ALARM_BLINK_EN
        blink_cnt_r <= '0;
`endif
      end
      if (bus.clear) begin
        state_r       <= ST_IDLE;
        pause_r       <= 1'b1;
        alarm_r       <= 1'b0;
        timer_clear_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE, ST_PAUSED: begin
            if (bus.start_stop) begin
              if (at_term_s) begin
                state_r <= ST_DONE;
                pause_r <= 1'b1;
                alarm_r <= 1'b1;
              end else begin
                state_r <= ST_RUN;
                pause_r <= 1'b0;
                alarm_r <= 1'b0;
              end
            end else if (bus.mode) begin
              up_down_r <= ~up_down_r;
            end
          end
          ST_RUN: begin
            if (bus.start_stop) begin
              state_r <= ST_PAUSED;
              pause_r <= 1'b1;
            end else if (bus.tick_in && at_term_s) begin
              state_r <= ST_DONE;
              pause_r <= 1'b1;
              alarm_r <= 1'b1;
            end
          end
          ST_DONE: begin
            if (bus.start_stop || timeout_s) begin
              state_r <= ST_IDLE;
              pause_r <= 1'b1;
              alarm_r <= 1'b0;
            end else begin
              if (ALARM_TIMEOUT != 0) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
              end
`ifdef ALARM_BLINK_EN
              if (blink_cnt_r == BL_LAST) begin
                blink_cnt_r <= '0;
                alarm_r     <= ~alarm_r;
              end else begin
                blink_cnt_r <= blink_cnt_r + BL_W'(1);
              end
`endif
            end
          end
          default: begin
            state_r <= ST_IDLE;
            pause_r <= 1'b1;
            alarm_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // The tick is swallowed at the terminal value so the timer never wraps.
  assign bus.tick_out    = bus.tick_in & (state_r == ST_RUN) & ~at_term_s;
  assign bus.pause       = pause_r;
  assign bus.up_down     = up_down_r;
  assign bus.timer_clear = timer_clear_r;
  assign bus.alarm       = alarm_r;
  assign bus.state       = state_r;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Self-checking bench for timer_run_ctrl: directed scenarios then random pulses,
// checked against a behavioural model plus a stand-in min:sec timer.
module tb_timer_run_ctrl;
  localparam int LIM_MIN  = 9;
  localparam int LIM_SEC  = 59;
  localparam int TIMEOUT  = 10;
  localparam int BLINK    = 4;
  localparam int TERM_UP  = LIM_MIN * 60 + LIM_SEC;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_DONE   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_run_ctrl_if bus();

  timer_run_ctrl #(
    .UP_LIMIT_MIN (LIM_MIN),
    .UP_LIMIT_SEC (LIM_SEC),
    .ALARM_TIMEOUT(TIMEOUT),
    .BLINK_DIV    (BLINK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: state number, direction, clear pulse, cycles spent in DONE.
  int m_state, m_up, m_clr, m_dc;
  // Stand-in timer: value in seconds (0..599) and value after the coming edge.
  int t, t_next;

  function automatic int exp_alarm();
    if (m_state != S_DONE) return 0;
`ifdef ALARM_BLINK_EN
    return ((m_dc / BLINK) % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk("state",       32'(bus.state),       m_state);
    chk("pause",       32'(bus.pause),       (m_state != S_RUN) ? 1 : 0);
    chk("up_down",     32'(bus.up_down),     m_up);
    chk("timer_clear", 32'(bus.timer_clear), m_clr);
    chk("alarm",       32'(bus.alarm),       exp_alarm());
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_up    = 1;
    m_clr   = 0;
    m_dc    = 0;
  endtask

  task automatic drive_idle();
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.mode       = 1'b0;
    bus.tick_in    = 1'b0;
  endtask

  // One clock: drive at negedge, check the gated tick, predict, check registers.
  task automatic step(input bit ss, input bit cl, input bit md, input bit tk);
    int at_term, e_tick, prev, spent;
    @(negedge clk);
    t = t_next;
    bus.min_low_digit  = 4'(t / 60);
    bus.sec_high_digit = 3'((t % 60) / 10);
    bus.sec_low_digit  = 4'(t % 10);
    bus.start_stop = ss;
    bus.clear      = cl;
    bus.mode       = md;
    bus.tick_in    = tk;
    #1;
    at_term = m_up ? (t == TERM_UP) : (t == 0);
    e_tick  = (tk && m_state == S_RUN && !at_term) ? 1 : 0;
    chk("tick_out", 32'(bus.tick_out), e_tick);
    if (m_clr != 0)      t_next = 0;
    else if (e_tick != 0) t_next = m_up ? (t + 1) % 600 : (t + 599) % 600;
    else                  t_next = t;
    prev  = m_state;
    m_clr = 0;
    if (cl) begin
      m_state = S_IDLE;
      m_clr   = 1;
    end else if (m_state == S_IDLE || m_state == S_PAUSED) begin
      if (ss)      m_state = at_term ? S_DONE : S_RUN;
      else if (md) m_up = 1 - m_up;
    end else if (m_state == S_RUN) begin
      if (ss)                 m_state = S_PAUSED;
      else if (tk && at_term) m_state = S_DONE;
    end else begin
      spent = m_dc + 1;
      if (ss || spent == TIMEOUT) m_state = S_IDLE;
      else                        m_dc = spent;
    end
    if (m_state == S_DONE && prev != S_DONE) m_dc = 0;
    @(posedge clk);
    #1;
    check_regs();
    drive_idle();
  endtask

  initial begin
    int r;
    reset = 1'b0;
    drive_idle();
    t = 0;
    t_next = 0;
    bus.min_low_digit  = 4'd0;
    bus.sec_high_digit = 3'd0;
    bus.sec_low_digit  = 4'd0;
    model_reset();
    #20;
    check_regs();
    chk("tick_out_rst", 32'(bus.tick_out), 0);
    #5 reset = 1'b1;

    // Run with a divide-by-7 tick, then stop; a tick while paused must be blocked.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, (i % 7) == 6);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Down count from 0:03: three ticks pass, the fourth enters DONE, then timeout.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    t_next = 3;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, (i % 3) == 2);

    // Up count from 9:57 stops at 9:59; start at the terminal value goes straight to DONE.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    t_next = 597;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b0, (i % 2) == 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Clear and start_stop together while running: clear wins.
    t_next = 100;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run returns everything to reset values.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    t = t_next;
    check_regs();
    chk("tick_out_midrst", 32'(bus.tick_out), 0);
    @(negedge clk);
    reset = 1'b1;

    // Random pulses with occasional presets near both terminal values.
    for (int i = 0; i < 600; i++) begin
      if (m_state != S_RUN && $urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 6);
        case (r)
          0: t_next = 0;
          1: t_next = 1;
          2: t_next = 2;
          3: t_next = 597;
          4: t_next = 598;
          5: t_next = 599;
          default: t_next = $urandom_range(0, 599);
        endcase
      end
      step($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
